usb_uart_sys_fifo: RTL and testbench

System-side end of the USB serial FIFO interface. Owns the TX FIFO, which the USB engine drains via tx_read, and the RX FIFO, which the USB engine fills via rx_write, each RX entry carrying a 9th error bit. Presents both FIFOs, status, interrupts and the 32-bit USB status word to the CPU through a simple word-addressed register port. Sits between the CPU peripheral bus and the USB UART bridge, in the 48 MHz domain.

---
 rtl/usb_uart_sys_fifo.sv | 182 ++++++++++++++++++
 tb/tb_usb_uart_sys_fifo.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_uart_sys_fifo.sv
// rtl/usb_uart_sys_fifo.sv - CPU-side TX/RX FIFOs, register port and interrupt for the USB UART bridge
module usb_uart_sys_fifo #(
  parameter int TX_AW = 4,
  parameter int RX_AW = 4
) (
  input  logic        clk_48mhz,
  input  logic        reset,
  input  logic [3:0]  reg_addr,
  input  logic        reg_wr,
  input  logic [31:0] reg_wdata,
  input  logic        reg_rd,
  output logic [31:0] reg_rdata,
  output logic        reg_rvalid,
  output logic        irq,
  output logic        tx_empty,
  input  logic        tx_read,
  output logic [7:0]  tx_fifo_rdata,
  output logic        rx_full,
  input  logic        rx_write,
  input  logic        rx_err,
  input  logic [7:0]  rx_fifo_wdata,
  input  logic [31:0] usb_status
);

  localparam int TX_DEPTH = 1 << TX_AW;
  localparam int RX_DEPTH = 1 << RX_AW;
  localparam logic [TX_AW:0] TX_FULL_CNT = {1'b1, {TX_AW{1'b0}}};
  localparam logic [TX_AW:0] TX_HALF_CNT = {2'b01, {(TX_AW-1){1'b0}}};
  localparam logic [RX_AW:0] RX_FULL_CNT = {1'b1, {RX_AW{1'b0}}};

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_USB    = 2'd3;

  logic [7:0]       tx_mem [0:TX_DEPTH-1];
  logic [TX_AW-1:0] tx_wptr, tx_rptr;
  logic [TX_AW:0]   tx_count;

  logic [8:0]       rx_mem [0:RX_DEPTH-1];
  logic [RX_AW-1:0] rx_wptr, rx_rptr;
  logic [RX_AW:0]   rx_count;

  logic rx_ie, tx_ie, err_ie;
  logic tx_ovf, rx_ovf;

  logic [1:0]  sel;
  logic        wr_data, rd_data, wr_ctrl;
  logic        tx_full, rx_empty;
  logic        tx_pop, tx_push, tx_drop, tx_clr;
  logic        rx_pop, rx_push, rx_drop, rx_clr;
  logic [31:0] rd_mux;

  logic unused_bits;
  assign unused_bits = ^{reg_addr[1:0], reg_wdata[31:18], reg_wdata[15:10]};

  assign sel     = reg_addr[3:2];
  assign wr_data = reg_wr && (sel == A_DATA);
  assign rd_data = reg_rd && (sel == A_DATA);
  assign wr_ctrl = reg_wr && (sel == A_CTRL);

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == TX_FULL_CNT);
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RX_FULL_CNT);

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign tx_pop  = tx_read && !tx_empty;
  assign tx_push = wr_data && (!tx_full || tx_pop);
  assign tx_drop = wr_data && tx_full && !tx_pop;
  assign tx_clr  = wr_ctrl && reg_wdata[8];

  assign rx_pop  = rd_data && !rx_empty;
  assign rx_push = rx_write && (!rx_full || rx_pop);
  assign rx_drop = rx_write && rx_full && !rx_pop;
  assign rx_clr  = wr_ctrl && reg_wdata[9];

  assign tx_fifo_rdata = tx_empty ? 8'h00 : tx_mem[tx_rptr];

  // TX pointers and occupancy; a clear overrides any concurrent push or pop.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else if (tx_clr) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
    end
  end

  // TX storage write.
  always_ff @(posedge clk_48mhz) begin
    if (tx_push && !tx_clr) tx_mem[tx_wptr] <= reg_wdata[7:0];
  end

  // RX pointers and occupancy; a clear overrides any concurrent push or pop.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else if (rx_clr) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

  // RX storage write, error bit kept above the data byte.
  always_ff @(posedge clk_48mhz) begin
    if (rx_push && !rx_clr) rx_mem[rx_wptr] <= {rx_err, rx_fifo_wdata};
  end

  // Control bits and sticky overflow flags; a new overflow wins over a same-cycle clear.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      rx_ie  <= 1'b0;
      tx_ie  <= 1'b0;
      err_ie <= 1'b0;
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        rx_ie  <= reg_wdata[0];
        tx_ie  <= reg_wdata[1];
        err_ie <= reg_wdata[2];
        if (reg_wdata[16]) tx_ovf <= 1'b0;
        if (reg_wdata[17]) rx_ovf <= 1'b0;
      end
      if (tx_drop)            tx_ovf <= 1'b1;
      if (rx_drop && !rx_clr) rx_ovf <= 1'b1;
    end
  end

  // Read-data selection from the state as it stands before this cycle's updates.
  always_comb begin
    rd_mux = '0;
    case (sel)
      A_DATA:   rd_mux = rx_empty ? 32'h8000_0000 : {23'd0, rx_mem[rx_rptr]};
      A_STATUS: rd_mux = {8'(tx_count), 8'(rx_count), 11'd0,
                          rx_ovf, tx_ovf, rx_full, tx_full, tx_empty};
      A_CTRL:   rd_mux = {29'd0, err_ie, tx_ie, rx_ie};
      A_USB:    rd_mux = usb_status;
      default:  rd_mux = '0;
    endcase
  end

  // Registered read response; data holds until the next read.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      reg_rdata  <= '0;
      reg_rvalid <= 1'b0;
    end else begin
      reg_rvalid <= reg_rd;
      if (reg_rd) reg_rdata <= rd_mux;
    end
  end

  // Level interrupt: RX data pending, TX at or below half, or any overflow.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= (rx_ie && !rx_empty) ||
             (tx_ie && (tx_count <= TX_HALF_CNT)) ||
             (err_ie && (tx_ovf || rx_ovf));
    end
  end

endmodule

// File: tb/tb_usb_uart_sys_fifo.sv
// tb/tb_usb_uart_sys_fifo.sv - self-checking bench for usb_uart_sys_fifo against a queue model
module tb_usb_uart_sys_fifo;

  logic        clk_48mhz;
  logic        reset;
  logic [3:0]  reg_addr;
  logic        reg_wr;
  logic [31:0] reg_wdata;
  logic        reg_rd;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;
  logic        irq;
  logic        tx_empty;
  logic        tx_read;
  logic [7:0]  tx_fifo_rdata;
  logic        rx_full;
  logic        rx_write;
  logic        rx_err;
  logic [7:0]  rx_fifo_wdata;
  logic [31:0] usb_status;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_q[$];
  logic [8:0]  rx_q[$];
  logic        m_rx_ie, m_tx_ie, m_err_ie, m_tx_ovf, m_rx_ovf, m_irq;
  logic [31:0] exp_rdata;
  logic        exp_rvalid;

  usb_uart_sys_fifo dut (
    .clk_48mhz     (clk_48mhz),
    .reset         (reset),
    .reg_addr      (reg_addr),
    .reg_wr        (reg_wr),
    .reg_wdata     (reg_wdata),
    .reg_rd        (reg_rd),
    .reg_rdata     (reg_rdata),
    .reg_rvalid    (reg_rvalid),
    .irq           (irq),
    .tx_empty      (tx_empty),
    .tx_read       (tx_read),
    .tx_fifo_rdata (tx_fifo_rdata),
    .rx_full       (rx_full),
    .rx_write      (rx_write),
    .rx_err        (rx_err),
    .rx_fifo_wdata (rx_fifo_wdata),
    .usb_status    (usb_status)
  );

  initial clk_48mhz = 1'b0;
  always #10 clk_48mhz = ~clk_48mhz;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = (32'(tx_q.size()) << 24) | (32'(rx_q.size()) << 16);
    if (m_rx_ovf)         s[4] = 1'b1;
    if (m_tx_ovf)         s[3] = 1'b1;
    if (rx_q.size() == 16) s[2] = 1'b1;
    if (tx_q.size() == 16) s[1] = 1'b1;
    if (tx_q.size() == 0)  s[0] = 1'b1;
    return s;
  endfunction

  function automatic logic [7:0] m_head();
    if (tx_q.size() == 0) return 8'h00;
    return tx_q[0];
  endfunction

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_rx_ie = 0; m_tx_ie = 0; m_err_ie = 0;
    m_tx_ovf = 0; m_rx_ovf = 0; m_irq = 0;
    exp_rdata = 32'h0;
    exp_rvalid = 0;
  endtask

  task automatic model_step(input logic wr, input logic rd, input logic [3:0] addr,
                            input logic [31:0] wd, input logic txr, input logic rxw,
                            input logic rxe, input logic [7:0] rxd);
    int tsz;
    int rsz;
    logic [1:0] a;
    bit tpop, tacc, rpop, racc;
    tsz = tx_q.size();
    rsz = rx_q.size();
    a = addr[3:2];
    if (rd) begin
      case (a)
        2'd0: exp_rdata = (rsz == 0) ? 32'h8000_0000 : {23'd0, rx_q[0]};
        2'd1: exp_rdata = m_status();
        2'd2: exp_rdata = {29'd0, m_err_ie, m_tx_ie, m_rx_ie};
        default: exp_rdata = usb_status;
      endcase
    end
    exp_rvalid = rd;
    m_irq = (m_rx_ie && rsz != 0) || (m_tx_ie && tsz <= 8) || (m_err_ie && (m_tx_ovf || m_rx_ovf));
    if (wr && a == 2'd2) begin
      m_rx_ie = wd[0]; m_tx_ie = wd[1]; m_err_ie = wd[2];
      if (wd[16]) m_tx_ovf = 0;
      if (wd[17]) m_rx_ovf = 0;
    end
    tpop = txr && tsz > 0;
    tacc = wr && a == 2'd0 && (tsz < 16 || tpop);
    if (wr && a == 2'd2 && wd[8]) tx_q.delete();
    else begin
      if (wr && a == 2'd0 && !tacc) m_tx_ovf = 1;
      if (tpop) void'(tx_q.pop_front());
      if (tacc) tx_q.push_back(wd[7:0]);
    end
    rpop = rd && a == 2'd0 && rsz > 0;
    racc = rxw && (rsz < 16 || rpop);
    if (wr && a == 2'd2 && wd[9]) rx_q.delete();
    else begin
      if (rxw && !racc) m_rx_ovf = 1;
      if (rpop) void'(rx_q.pop_front());
      if (racc) rx_q.push_back({rxe, rxd});
    end
  endtask

  task automatic do_cycle(input logic wr, input logic rd, input logic [3:0] addr,
                          input logic [31:0] wd, input logic txr, input logic rxw,
                          input logic rxe, input logic [7:0] rxd);
    reg_wr = wr; reg_rd = rd; reg_addr = addr; reg_wdata = wd;
    tx_read = txr; rx_write = rxw; rx_err = rxe; rx_fifo_wdata = rxd;
    model_step(wr, rd, addr, wd, txr, rxw, rxe, rxd);
    @(posedge clk_48mhz); #1;
    reg_wr = 0; reg_rd = 0; tx_read = 0; rx_write = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk_48mhz);
    #1 reset = 0;
    model_reset();
    checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL reset_tx_empty got %0b exp 1", tx_empty); end
    checks++; if (rx_full !== 1'b0) begin errors++; $display("FAIL reset_rx_full got %0b exp 0", rx_full); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b exp 0", irq); end
    checks++; if (reg_rvalid !== 1'b0 || reg_rdata !== 32'h0) begin errors++; $display("FAIL reset_rd got %0b/%h exp 0/0", reg_rvalid, reg_rdata); end
    checks++; if (tx_fifo_rdata !== 8'h00) begin errors++; $display("FAIL reset_tx_rdata got %h exp 00", tx_fifo_rdata); end
    do_cycle(0, 1, 4'h4, 0, 0, 0, 0, 0);
    checks++; if (reg_rvalid !== 1'b1 || reg_rdata !== 32'h0000_0001) begin errors++; $display("FAIL reset_status got %0b/%h exp 1/00000001", reg_rvalid, reg_rdata); end
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (reg_rvalid !== 1'b0 || reg_rdata !== 32'h0000_0001) begin errors++; $display("FAIL rvalid_pulse got %0b/%h exp 0/00000001", reg_rvalid, reg_rdata); end
  endtask

  task automatic test_tx_basic();
    do_cycle(1, 0, 4'h0, 32'h41, 0, 0, 0, 0);
    do_cycle(1, 0, 4'h0, 32'h42, 0, 0, 0, 0);
    do_cycle(1, 0, 4'h0, 32'h43, 0, 0, 0, 0);
    checks++; if (tx_fifo_rdata !== 8'h41 || tx_empty !== 1'b0) begin errors++; $display("FAIL tx_head0 got %h/%0b exp 41/0", tx_fifo_rdata, tx_empty); end
    do_cycle(0, 0, 0, 0, 1, 0, 0, 0);
    checks++; if (tx_fifo_rdata !== 8'h42) begin errors++; $display("FAIL tx_head1 got %h exp 42", tx_fifo_rdata); end
    do_cycle(0, 0, 0, 0, 1, 0, 0, 0);
    checks++; if (tx_fifo_rdata !== 8'h43) begin errors++; $display("FAIL tx_head2 got %h exp 43", tx_fifo_rdata); end
    do_cycle(0, 0, 0, 0, 1, 0, 0, 0);
    checks++; if (tx_empty !== 1'b1 || tx_fifo_rdata !== 8'h00) begin errors++; $display("FAIL tx_drained got %0b/%h exp 1/00", tx_empty, tx_fifo_rdata); end
    do_cycle(0, 0, 0, 0, 1, 0, 0, 0);
    do_cycle(0, 1, 4'h4, 0, 0, 0, 0, 0);
    checks++; if (reg_rdata !== 32'h0000_0001) begin errors++; $display("FAIL tx_underflow_status got %h exp 00000001", reg_rdata); end
  endtask

  task automatic test_tx_overflow();
    for (int i = 0; i < 17; i++) do_cycle(1, 0, 4'h0, 32'(i + 8'h60), 0, 0, 0, 0);
    do_cycle(0, 1, 4'h4, 0, 0, 0, 0, 0);
    checks++; if (reg_rdata !== 32'h1000_000A || reg_rdata !== exp_rdata) begin errors++; $display("FAIL tx_ovf_status got %h exp %h", reg_rdata, exp_rdata); end
    checks++; if (tx_fifo_rdata !== 8'h60) begin errors++; $display("FAIL tx_ovf_head got %h exp 60", tx_fifo_rdata); end
    do_cycle(1, 0, 4'h8, 32'h0001_0000, 0, 0, 0, 0);
    do_cycle(0, 1, 4'h4, 0, 0, 0, 0, 0);
    checks++; if (reg_rdata !== 32'h1000_0002) begin errors++; $display("FAIL tx_ovf_clear got %h exp 10000002", reg_rdata); end
    for (int i = 0; i < 16; i++) begin
      do_cycle(0, 0, 0, 0, 1, 0, 0, 0);
      checks++; if (tx_fifo_rdata !== m_head()) begin errors++; $display("FAIL tx_full_drain got %h exp %h", tx_fifo_rdata, m_head()); end
    end
  endtask

  task automatic test_rx_basic();
    do_cycle(0, 0, 0, 0, 0, 1, 1, 8'hA5);
    do_cycle(1, 0, 4'h8, 32'h1, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq_set got %0b exp 1", irq); end
    do_cycle(0, 1, 4'h0, 0, 0, 0, 0, 0);
    checks++; if (reg_rvalid !== 1'b1 || reg_rdata !== 32'h0000_01A5) begin errors++; $display("FAIL rx_read got %0b/%h exp 1/000001a5", reg_rvalid, reg_rdata); end
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_drop got %0b exp 0", irq); end
    do_cycle(0, 1, 4'h0, 0, 0, 0, 0, 0);
    checks++; if (reg_rdata !== 32'h8000_0000) begin errors++; $display("FAIL rx_empty_read got %h exp 80000000", reg_rdata); end
    usb_status = 32'hCAFE_1234;
    do_cycle(0, 1, 4'hC, 0, 0, 0, 0, 0);
    checks++; if (reg_rdata !== 32'hCAFE_1234) begin errors++; $display("FAIL usb_status got %h exp cafe1234", reg_rdata); end
    do_cycle(0, 1, 4'h8, 0, 0, 0, 0, 0);
    checks++; if (reg_rdata !== 32'h1) begin errors++; $display("FAIL ctrl_read got %h exp 00000001", reg_rdata); end
    do_cycle(1, 0, 4'h8, 32'h0, 0, 0, 0, 0);
  endtask

  task automatic test_rx_wrap();
    logic [7:0] d;
    logic e;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom); e = 1'($urandom);
      do_cycle(0, 0, 0, 0, 0, 1, e, d);
    end
    checks++; if (rx_full !== 1'b1) begin errors++; $display("FAIL rx_full_set got %0b exp 1", rx_full); end
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom); e = 1'($urandom);
      do_cycle(0, 1, 4'h0, 0, 0, 1, e, d);
      checks++; if (reg_rdata !== exp_rdata || rx_full !== 1'b1) begin errors++; $display("FAIL rx_wrap_rw got %h/%0b exp %h/1", reg_rdata, rx_full, exp_rdata); end
    end
    do_cycle(0, 1, 4'h4, 0, 0, 0, 0, 0);
    checks++; if (reg_rdata[23:16] !== 8'd16 || reg_rdata[4] !== 1'b0) begin errors++; $display("FAIL rx_wrap_status got %h exp rx_count 16 rx_ovf 0", reg_rdata); end
    do_cycle(0, 0, 0, 0, 0, 1, 0, 8'hEE);
    do_cycle(0, 1, 4'h4, 0, 0, 0, 0, 0);
    checks++; if (reg_rdata !== exp_rdata || reg_rdata[4] !== 1'b1) begin errors++; $display("FAIL rx_ovf_status got %h exp %h", reg_rdata, exp_rdata); end
    for (int i = 0; i < 16; i++) begin
      do_cycle(0, 1, 4'h0, 0, 0, 0, 0, 0);
      checks++; if (reg_rdata !== exp_rdata) begin errors++; $display("FAIL rx_drain got %h exp %h", reg_rdata, exp_rdata); end
    end
    do_cycle(1, 0, 4'h8, 32'h0002_0000, 0, 0, 0, 0);
  endtask

  task automatic test_clear();
    for (int i = 0; i < 5; i++) do_cycle(1, 0, 4'h0, 32'(8'h30 + i), 0, 0, 0, 0);
    do_cycle(1, 0, 4'h8, 32'h100, 1, 0, 0, 0);
    checks++; if (tx_empty !== 1'b1 || tx_fifo_rdata !== 8'h00) begin errors++; $display("FAIL tx_clear got %0b/%h exp 1/00", tx_empty, tx_fifo_rdata); end
    do_cycle(0, 1, 4'h4, 0, 0, 0, 0, 0);
    checks++; if (reg_rdata[31:24] !== 8'd0 || reg_rdata[3] !== 1'b0) begin errors++; $display("FAIL tx_clear_status got %h exp tx_count 0 tx_ovf 0", reg_rdata); end
    for (int i = 0; i < 16; i++) do_cycle(0, 0, 0, 0, 0, 1, 0, 8'(i));
    do_cycle(1, 0, 4'h8, 32'h200, 0, 1, 1, 8'h77);
    checks++; if (rx_full !== 1'b0) begin errors++; $display("FAIL rx_clear_full got %0b exp 0", rx_full); end
    do_cycle(0, 1, 4'h4, 0, 0, 0, 0, 0);
    checks++; if (reg_rdata !== 32'h0000_0001) begin errors++; $display("FAIL rx_clear_status got %h exp 00000001", reg_rdata); end
  endtask

  task automatic test_random();
    logic wr, rd, txr, rxw;
    logic [3:0] addr;
    logic [31:0] wd;
    bit fill;
    for (int i = 0; i < 3000; i++) begin
      fill = ((i / 150) % 2) == 0;
      wr   = fill ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 4) == 0);
      rd   = fill ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
      txr  = fill ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
      rxw  = fill ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) == 0);
      addr = {2'($urandom_range(0, 3)), 2'b00};
      if (addr[3:2] == 2'd2 && wr && $urandom_range(0, 3) != 0) addr = 4'h0;
      wd = $urandom;
      if ($urandom_range(0, 7) != 0) wd[9:8] = 2'b00;
      usb_status = $urandom;
      do_cycle(wr, rd, addr, wd, txr, rxw, 1'($urandom), 8'($urandom));
      checks++; if (reg_rvalid !== exp_rvalid || reg_rdata !== exp_rdata) begin errors++; $display("FAIL rnd_read @%0d got %0b/%h exp %0b/%h", i, reg_rvalid, reg_rdata, exp_rvalid, exp_rdata); end
      checks++; if (tx_empty !== (tx_q.size() == 0) || rx_full !== (rx_q.size() == 16)) begin errors++; $display("FAIL rnd_flags @%0d got %0b%0b exp %0b%0b", i, tx_empty, rx_full, tx_q.size() == 0, rx_q.size() == 16); end
      checks++; if (tx_fifo_rdata !== m_head()) begin errors++; $display("FAIL rnd_tx_head @%0d got %h exp %h", i, tx_fifo_rdata, m_head()); end
      checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq @%0d got %0b exp %0b", i, irq, m_irq); end
    end
  endtask

  task automatic test_async_reset();
    do_cycle(1, 0, 4'h0, 32'h11, 0, 0, 0, 0);
    do_cycle(1, 0, 4'h8, 32'h7, 0, 1, 0, 8'h22);
    reg_rd = 1; reg_addr = 4'h4;
    #5 reset = 1;
    #2;
    checks++; if (tx_empty !== 1'b1 || irq !== 1'b0 || reg_rdata !== 32'h0) begin errors++; $display("FAIL async_reset got %0b/%0b/%h exp 1/0/0", tx_empty, irq, reg_rdata); end
    @(posedge clk_48mhz); #1;
    checks++; if (reg_rvalid !== 1'b0) begin errors++; $display("FAIL async_rvalid got %0b exp 0", reg_rvalid); end
    reg_rd = 0;
    reset = 0;
    model_reset();
    do_cycle(0, 1, 4'h8, 0, 0, 0, 0, 0);
    checks++; if (reg_rdata !== 32'h0) begin errors++; $display("FAIL async_ctrl got %h exp 0", reg_rdata); end
    do_cycle(0, 1, 4'h4, 0, 0, 0, 0, 0);
    checks++; if (reg_rdata !== 32'h0000_0001) begin errors++; $display("FAIL async_status got %h exp 00000001", reg_rdata); end
  endtask

  initial begin
    reset = 1;
    reg_addr = 0; reg_wr = 0; reg_wdata = 0; reg_rd = 0;
    tx_read = 0; rx_write = 0; rx_err = 0; rx_fifo_wdata = 0;
    usb_status = 32'h0;
    model_reset();
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_rx_basic();
    test_rx_wrap();
    test_clear();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
